// File: rtl/aes_ctrl_pkg.sv
// Shared types and widths for the AES request arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_ctrl_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 256;
  localparam int NUM_REQ   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } aes_state_e;

  // One-hot response strobe for a requester index.
  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/aes_req_arbiter_if.sv
// Requester-side job/response bundle for the AES request arbiter.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the job and the response channel.
interface aes_req_arbiter_if;
  import aes_ctrl_pkg::*;

  logic [NUM_REQ-1:0]           req_valid_i;
  logic [NUM_REQ-1:0]           req_ready_o;
  logic [NUM_REQ*AES_BLK_W-1:0] req_pt_i;
  logic [NUM_REQ*AES_KEY_W-1:0] req_key_i;
  logic [NUM_REQ-1:0]           rsp_valid_o;
  logic [NUM_REQ-1:0]           rsp_ready_i;
  logic [AES_BLK_W-1:0]         rsp_ct_o;

  // Arbiter side.
  modport slave (
    input  req_valid_i, req_pt_i, req_key_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_ct_o
  );

  // Requester side.
  modport master (
    output req_valid_i, req_pt_i, req_key_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_ct_o
  );

endinterface

// File: rtl/aes_rr_arb2.sv
// Combinational 2-way round-robin grant; rr_q names the favoured requester on a tie.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; grant is zero when no request is present.
module aes_rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_q,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  // A lone requester always wins; a tie goes to the round-robin pointer.
  always_comb begin
    gnt     = 2'b00;
    gnt_idx = 1'b0;
    case (req)
      2'b01: begin
        gnt     = 2'b01;
        gnt_idx = 1'b0;
      end
      2'b10: begin
        gnt     = 2'b10;
        gnt_idx = 1'b1;
      end
      2'b11: begin
        gnt     = rr_q ? 2'b10 : 2'b01;
        gnt_idx = rr_q;
      end
      default: begin
        gnt     = 2'b00;
        gnt_idx = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Owns the single AES-256 core: round-robin job accept, fixed-latency run, one-hot response.
// Latency: accept edge E0 -> rsp_valid_o at E0+CORE_LATENCY; min job period CORE_LATENCY+2.
// Backpressure: one job in flight; req_ready_o low outside IDLE, RESP holds until owner ready.
// Optional feature: define AES_ARB_IRQ_EN to build the sticky job-complete interrupt.
module aes_req_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int CORE_LATENCY = 16  // legal range 1..255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  aes_req_arbiter_if.slave     req_if,
  output logic [AES_BLK_W-1:0] core_pt_o,
  output logic [AES_KEY_W-1:0] core_key_o,
  output logic                 core_en_o,
  input  logic [AES_BLK_W-1:0] core_ct_i,
  output logic                 busy_o,
  output logic                 owner_o,
  output logic                 irq_o,
  input  logic                 irq_ack_i
);

  localparam int CNT_W = $clog2(CORE_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORE_LATENCY - 1);

  aes_state_e           state_q, state_d;
  logic                 rr_q, rr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 owner_q, owner_d;
  logic                 busy_q, busy_d;
  logic [AES_BLK_W-1:0] pt_q, pt_d;
  logic [AES_KEY_W-1:0] key_q, key_d;
  logic [AES_BLK_W-1:0] ct_q, ct_d;

  logic [NUM_REQ-1:0]   gnt;
  logic                 gnt_idx;
  logic                 accept;
  logic [AES_BLK_W-1:0] sel_pt;
  logic [AES_KEY_W-1:0] sel_key;

  aes_rr_arb2 u_arb (
    .req     (req_if.req_valid_i),
    .rr_q    (rr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Operand slice of whichever requester currently holds the grant.
  always_comb begin
    sel_pt  = gnt_idx ? req_if.req_pt_i[2*AES_BLK_W-1:AES_BLK_W]
                      : req_if.req_pt_i[AES_BLK_W-1:0];
    sel_key = gnt_idx ? req_if.req_key_i[2*AES_KEY_W-1:AES_KEY_W]
                      : req_if.req_key_i[AES_KEY_W-1:0];
  end

  // A job is taken only in IDLE; ready is also forced low while reset is asserted.
  assign accept             = (state_q == IDLE) && (gnt != 2'b00);
  assign req_if.req_ready_o = ((state_q == IDLE) && wb_rst_ni) ? gnt : 2'b00;

  // Next-state: accept and latch operands, count down the core latency, hold response.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    pt_d    = pt_q;
    key_d   = key_q;
    ct_d    = ct_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pt_d    = sel_pt;
          key_d   = sel_key;
          owner_d = gnt_idx;
          cnt_d   = CNT_LOAD;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          ct_d    = core_ct_i;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        // Only the owner's ready bit completes the job.
        if (req_if.rsp_ready_i[owner_q]) begin
          rr_d    = ~owner_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset discards any job in flight.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      pt_q    <= '0;
      key_q   <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
    end
  end

  assign core_pt_o          = pt_q;
  assign core_key_o         = key_q;
  assign core_en_o          = (state_q == RUN);
  assign busy_o             = busy_q;
  assign owner_o            = owner_q;
  assign req_if.rsp_ct_o    = ct_q;
  assign req_if.rsp_valid_o = (state_q == RESP) ? idx2onehot(owner_q) : 2'b00;

`ifdef AES_ARB_IRQ_EN
  logic irq_q;
  logic irq_set;

  assign irq_set = (state_q == RUN) && (state_d == RESP);

  // Sticky completion flag; a set on the same edge as an ack takes priority.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_q <= 1'b0;
    end else if (irq_set) begin
      irq_q <= 1'b1;
    end else if (irq_ack_i) begin
      irq_q <= 1'b0;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_ack;

  assign unused_irq_ack = irq_ack_i;
  assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Self-checking bench for aes_req_arbiter: directed scenarios plus randomized traffic.
// Latency: checks accept-to-response of CORE_LATENCY cycles against a transaction model.
// Backpressure: drives random request withdrawal and response stalls.
module tb_aes_req_arbiter;

  localparam int L = 16;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] core_pt_o;
  logic [255:0] core_key_o;
  logic         core_en_o;
  logic [127:0] core_ct_i;
  logic         busy_o;
  logic         owner_o;
  logic         irq_o;
  logic         irq_ack_i;

  aes_req_arbiter_if bus ();

  aes_req_arbiter #(.CORE_LATENCY(L)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .req_if     (bus),
    .core_pt_o  (core_pt_o),
    .core_key_o (core_key_o),
    .core_en_o  (core_en_o),
    .core_ct_i  (core_ct_i),
    .busy_o     (busy_o),
    .owner_o    (owner_o),
    .irq_o      (irq_o),
    .irq_ack_i  (irq_ack_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stand-in for the AES core: the FIPS vector maps to its published ciphertext, anything
  // else to a keyed mix. The result is only presented once enable has been high L cycles.
  function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [255:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ key[127:0] ^ {key[200:128], key[255:201]};
  endfunction

  int en_run = 0;
  always @(negedge clk) begin
    if (core_en_o) en_run = en_run + 1;
    else           en_run = 0;
    if (en_run == L) core_ct_i = core_fn(core_pt_o, core_key_o);
    else             core_ct_i = {$urandom, $urandom, $urandom, $urandom};
  end

  // Transaction model: one job in flight, tagged with the cycle it was accepted.
  bit           m_busy = 0;
  bit           m_rr   = 0;
  bit           m_irq  = 0;
  bit           m_owner;
  int           m_t0;
  logic [127:0] m_pt;
  logic [255:0] m_key;
  logic [127:0] m_ct;
  int           acc_cyc[$];
  bit           acc_own[$];
  logic [1:0]   hs_rv[$];
  bit           hs_own[$];

  always @(negedge clk) begin
    int         age;
    bit         irq_set;
    logic [1:0] exp_rdy;
    logic [1:0] exp_rv;
    if (!rst_n) begin
      m_busy = 0;
      m_rr   = 0;
      m_irq  = 0;
    end else begin
      age     = cyc - m_t0;
      irq_set = m_busy && (age == L);
      if (m_busy) begin
        exp_rv = (age > L) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        check_eq("core_en",    core_en_o, age <= L);
        check_eq("rsp_valid",  bus.rsp_valid_o, exp_rv);
        check_eq("rdy_busy",   bus.req_ready_o, 2'b00);
        check_eq("busy_run",   busy_o, 1'b1);
        check_eq("owner",      owner_o, m_owner);
        check_eq("core_pt",    core_pt_o, m_pt);
        check_eq("core_key",   core_key_o, m_key);
        if (age > L) begin
          check_eq("rsp_ct", bus.rsp_ct_o, m_ct);
          if (bus.rsp_ready_i[m_owner]) begin
            hs_rv.push_back(bus.rsp_valid_o);
            hs_own.push_back(owner_o);
            m_busy = 0;
            m_rr   = ~m_owner;
          end
        end
      end else begin
        case (bus.req_valid_i)
          2'b01:   exp_rdy = 2'b01;
          2'b10:   exp_rdy = 2'b10;
          2'b11:   exp_rdy = m_rr ? 2'b10 : 2'b01;
          default: exp_rdy = 2'b00;
        endcase
        check_eq("busy_idle",  busy_o, 1'b0);
        check_eq("en_idle",    core_en_o, 1'b0);
        check_eq("rv_idle",    bus.rsp_valid_o, 2'b00);
        check_eq("req_ready",  bus.req_ready_o, exp_rdy);
        if (exp_rdy != 2'b00) begin
          m_busy  = 1;
          m_t0    = cyc;
          m_owner = exp_rdy[1];
          m_pt    = m_owner ? bus.req_pt_i[255:128] : bus.req_pt_i[127:0];
          m_key   = m_owner ? bus.req_key_i[511:256] : bus.req_key_i[255:0];
          m_ct    = core_fn(m_pt, m_key);
          acc_cyc.push_back(cyc);
          acc_own.push_back(m_owner);
        end
      end
`ifdef AES_ARB_IRQ_EN
      check_eq("irq", irq_o, m_irq);
      if (irq_set)        m_irq = 1;
      else if (irq_ack_i) m_irq = 0;
`else
      check_eq("irq_off", irq_o, 1'b0);
`endif
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},  busy_o, 1'b0);
    check_eq({tag, "_en"},    core_en_o, 1'b0);
    check_eq({tag, "_rv"},    bus.rsp_valid_o, 2'b00);
    check_eq({tag, "_rdy"},   bus.req_ready_o, 2'b00);
    check_eq({tag, "_pt"},    core_pt_o, 128'h0);
    check_eq({tag, "_key"},   core_key_o, 256'h0);
    check_eq({tag, "_ct"},    bus.rsp_ct_o, 128'h0);
    check_eq({tag, "_owner"}, owner_o, 1'b0);
    check_eq({tag, "_irq"},   irq_o, 1'b0);
  endtask

  task automatic wait_acc(input int target, input int budget);
    int i;
    for (i = 0; i < budget && acc_cyc.size() < target; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("acc_count", acc_cyc.size(), target);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int i;
    for (i = 0; i < budget && hs_rv.size() < target; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("hs_count", hs_rv.size(), target);
  endtask

  task automatic wait_rsp(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = (bus.rsp_valid_o != 2'b00);
    end
    check_eq("rsp_seen", seen, 1'b1);
  endtask

  task automatic rand_data();
    bus.req_pt_i  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.req_key_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic run_fips(input string tag);
    int         en_n = 0;
    bit         seen = 0;
    logic [1:0] rv   = 2'b00;
    logic [127:0] ct = '0;
    int         hb   = hs_rv.size();
    @(posedge clk);
    #1;
    bus.req_pt_i    = {128'h0, FIPS_PT};
    bus.req_key_i   = {256'h0, FIPS_KEY};
    bus.req_valid_i = 2'b01;
    bus.rsp_ready_i = 2'b01;
    @(posedge clk);
    #1 bus.req_valid_i = 2'b00;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid_o != 2'b00) begin
        seen = 1;
        rv   = bus.rsp_valid_o;
        ct   = bus.rsp_ct_o;
      end else if (core_en_o) begin
        en_n++;
      end
    end
    check_eq({tag, "_en_cycles"}, en_n, L);
    check_eq({tag, "_rv"}, rv, 2'b01);
    check_eq({tag, "_ct"}, ct, FIPS_CT);
    wait_hs(hb + 1, 10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int base, hb, stall_rv, stall_ct;
    logic [127:0] saved_ct;

    rst_n           = 1'b0;
    irq_ack_i       = 1'b0;
    bus.req_valid_i = 2'b11;
    bus.rsp_ready_i = 2'b00;
    bus.req_pt_i    = '0;
    bus.req_key_i   = '0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    bus.req_valid_i = 2'b00;
    #1 rst_n = 1'b1;

    // FIPS-197 AES-256 job on requester 0.
    run_fips("fips");

    // Simultaneous requests right after reset: 0 first, then 1.
    pulse_reset();
    base = acc_cyc.size();
    hb   = hs_rv.size();
    @(posedge clk);
    #1;
    rand_data();
    bus.req_valid_i = 2'b11;
    bus.rsp_ready_i = 2'b11;
    wait_acc(base + 2, 60);
    @(posedge clk);
    #1 bus.req_valid_i = 2'b00;
    wait_hs(hb + 2, 60);
    check_eq("tie_acc0", acc_own[base], 1'b0);
    check_eq("tie_acc1", acc_own[base+1], 1'b1);
    check_eq("tie_own0", hs_own[hb], 1'b0);
    check_eq("tie_own1", hs_own[hb+1], 1'b1);
    check_eq("tie_rv0",  hs_rv[hb], 2'b01);
    check_eq("tie_rv1",  hs_rv[hb+1], 2'b10);

    // Requester 1 back to back, response always ready.
    base = acc_cyc.size();
    hb   = hs_rv.size();
    @(posedge clk);
    #1;
    rand_data();
    bus.req_valid_i = 2'b10;
    bus.rsp_ready_i = 2'b11;
    wait_acc(base + 3, 100);
    @(posedge clk);
    #1 bus.req_valid_i = 2'b00;
    wait_hs(hb + 3, 60);
    for (int k = 0; k < 3; k++) check_eq("b2b_owner", acc_own[base+k], 1'b1);
    check_eq("b2b_gap1", acc_cyc[base+1] - acc_cyc[base], L + 2);
    check_eq("b2b_gap2", acc_cyc[base+2] - acc_cyc[base+1], L + 2);

    // Response stalled for 10 cycles with both requests pending.
    hb = hs_rv.size();
    @(posedge clk);
    #1;
    rand_data();
    bus.req_valid_i = 2'b01;
    bus.rsp_ready_i = 2'b00;
    @(posedge clk);
    #1 bus.req_valid_i = 2'b00;
    wait_rsp(40);
    saved_ct = bus.rsp_ct_o;
    @(posedge clk);
    #1 bus.req_valid_i = 2'b11;
    stall_rv = 0;
    stall_ct = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid_o != 2'b01) stall_rv++;
      if (bus.rsp_ct_o != saved_ct) stall_ct++;
      check_eq("stall_rdy", bus.req_ready_o, 2'b00);
    end
    check_eq("stall_rv_moved", stall_rv, 0);
    check_eq("stall_ct_moved", stall_ct, 0);
    @(posedge clk);
    #1;
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 2'b01;
    wait_hs(hb + 1, 10);

    // Reset at RUN cycle 5 discards the job.
    @(posedge clk);
    #1;
    rand_data();
    bus.req_valid_i = 2'b01;
    bus.rsp_ready_i = 2'b11;
    @(posedge clk);
    #1 bus.req_valid_i = 2'b00;
    repeat (4) @(posedge clk);
    #1 bus.req_valid_i = 2'b11;
    #1 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    bus.req_valid_i = 2'b00;
    @(posedge clk);
    #2 rst_n = 1'b1;
    stall_rv = 0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid_o != 2'b00) stall_rv++;
    end
    check_eq("midrst_no_rsp", stall_rv, 0);
    run_fips("after_rst");

`ifdef AES_ARB_IRQ_EN
    // Sticky interrupt, cleared by a one-cycle ack.
    hb = hs_rv.size();
    @(posedge clk);
    #1;
    rand_data();
    bus.req_valid_i = 2'b10;
    bus.rsp_ready_i = 2'b00;
    @(posedge clk);
    #1 bus.req_valid_i = 2'b00;
    wait_rsp(40);
    check_eq("irq_rise", irq_o, 1'b1);
    @(posedge clk);
    #1 bus.rsp_ready_i = 2'b10;
    wait_hs(hb + 1, 5);
    @(posedge clk);
    #1 bus.rsp_ready_i = 2'b00;
    @(negedge clk);
    #1 check_eq("irq_hold", irq_o, 1'b1);
    @(posedge clk);
    #1 irq_ack_i = 1'b1;
    @(posedge clk);
    #1 irq_ack_i = 1'b0;
    check_eq("irq_clear", irq_o, 1'b0);
    // Ack held across the set edge: set wins.
    hb = hs_rv.size();
    bus.req_valid_i = 2'b01;
    irq_ack_i       = 1'b1;
    @(posedge clk);
    #1 bus.req_valid_i = 2'b00;
    wait_rsp(40);
    check_eq("irq_set_wins", irq_o, 1'b1);
    @(posedge clk);
    #1;
    irq_ack_i       = 1'b0;
    bus.rsp_ready_i = 2'b01;
    wait_hs(hb + 1, 5);
`endif

    // Randomized traffic: withdrawals, changing data, random response stalls and acks.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rand_data();
      bus.req_valid_i = 2'($urandom_range(0, 3));
      bus.rsp_ready_i = 2'($urandom_range(0, 3));
      irq_ack_i       = ($urandom_range(0, 7) == 0);
    end
    @(posedge clk);
    #1;
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 2'b11;
    irq_ack_i       = 1'b0;
    repeat (L + 4) @(posedge clk);
    @(negedge clk);
    #1 check_eq("drain_busy", busy_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
